// File: rtl/csr_ctrl_pkg.sv
// CSR control shared definitions: op encodings, CSR addresses, ECALL cause code,
// FSM state type and the request legality check.
// Imported by csr_ctrl and csr_alu; purely declarative, no hardware of its own.
package csr_ctrl_pkg;

  // Request op encodings from the execute stage
  localparam logic [2:0] OP_CSRRW = 3'b001;
  localparam logic [2:0] OP_CSRRS = 3'b010;
  localparam logic [2:0] OP_CSRRC = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  // Machine-mode CSR addresses implemented by this hart
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // mcause value for an environment call from M-mode
  localparam int unsigned CAUSE_ECALL_M = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_READ2,
    ST_WRITE,
    ST_RESP
  } state_e;

  function automatic logic is_csr_op(input logic [2:0] op);
    return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
  endfunction

  function automatic logic addr_legal(input logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MHARTID: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Illegal: unknown op, unimplemented CSR, or an effective write to a
  // read-only CSR (addr[11:10]==11). RS/RC with src==0 do not write, so
  // they may read read-only CSRs.
  function automatic logic req_illegal(input logic [2:0] op, input logic [11:0] a,
                                       input logic src_nz);
    logic writes;
    writes = (op == OP_CSRRW) || src_nz;
    if ((op == OP_ECALL) || (op == OP_MRET)) return 1'b0;
    if (!is_csr_op(op)) return 1'b1;
    return !addr_legal(a) || (writes && (a[11:10] == 2'b11));
  endfunction

endpackage

// File: rtl/csr_alu.sv
// CSR read-modify-write arithmetic for CSRRW/CSRRS/CSRRC.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: op (request op), old_val (current CSR value), src (rs1 operand),
//        new_val (value to write), wr_en (0 when RS/RC with src==0 suppress the write).
module csr_alu
  import csr_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] new_val,
  output logic            wr_en
);

  always_comb begin
    new_val = old_val;
    wr_en   = 1'b0;
    case (op)
      OP_CSRRW: begin
        new_val = src;
        wr_en   = 1'b1;
      end
      OP_CSRRS: begin
        new_val = old_val | src;
        wr_en   = |src;
      end
      OP_CSRRC: begin
        new_val = old_val & ~src;
        wr_en   = |src;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// CSR access / trap sequencer between execute stage and the CSR file.
// Latency: accept edge T -> resp_valid_o in cycle T+3 (MRET T+4); one request in flight.
// Backpressure: req_ready_o high only in IDLE; response is a one-cycle pulse, never stalled.
// Ports: req_* request from execute; resp_* result/redirect; csr_raddr_o/csr_rdata_i
//        combinational CSR read; csr_we_o/waddr/wdata generic write; mepc/mcause/mie trap strobes.
module csr_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_op_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_src_i,
  input  logic [XLEN-1:0]   req_pc_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_redirect_o,
  output logic [XLEN-1:0]   resp_target_o,
  output logic              resp_illegal_o,
  output logic [ADDR_W-1:0] csr_raddr_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              csr_we_o,
  output logic [ADDR_W-1:0] csr_waddr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              csr_we_mepc_o,
  output logic [XLEN-1:0]   csr_wdata_mepc_o,
  output logic              csr_we_mcause_o,
  output logic [XLEN-1:0]   csr_wdata_mcause_o,
  output logic              csr_exception_mie_req_o
);

  state_e            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   src_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   tgt_q;
  logic              illegal_q;

  logic [11:0]       req_addr12;
  logic [XLEN-1:0]   alu_old;
  logic [XLEN-1:0]   alu_new;
  logic              alu_wr;
  logic [XLEN-1:0]   mret_val;

  assign req_addr12 = 12'(req_addr_i);

  // Strobes are registered on the edge entering WRITE, so in READ the ALU
  // must see the live read data rather than the not-yet-captured old_q.
  assign alu_old = (state == ST_READ) ? csr_rdata_i : old_q;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op      (op_q),
    .old_val (alu_old),
    .src     (src_q),
    .new_val (alu_new),
    .wr_en   (alu_wr)
  );

  // MRET: MIE <= MPIE, MPIE <= 1, everything else cleared
  always_comb begin
    mret_val    = '0;
    mret_val[3] = old_q[7];
    mret_val[7] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= ST_IDLE;
      op_q                    <= '0;
      addr_q                  <= '0;
      src_q                   <= '0;
      pc_q                    <= '0;
      old_q                   <= '0;
      tgt_q                   <= '0;
      illegal_q               <= 1'b0;
      req_ready_o             <= 1'b1;
      resp_valid_o            <= 1'b0;
      resp_rdata_o            <= '0;
      resp_redirect_o         <= 1'b0;
      resp_target_o           <= '0;
      resp_illegal_o          <= 1'b0;
      csr_raddr_o             <= '0;
      csr_we_o                <= 1'b0;
      csr_waddr_o             <= '0;
      csr_wdata_o             <= '0;
      csr_we_mepc_o           <= 1'b0;
      csr_wdata_mepc_o        <= '0;
      csr_we_mcause_o         <= 1'b0;
      csr_wdata_mcause_o      <= '0;
      csr_exception_mie_req_o <= 1'b0;
    end else begin
      // Every output is a single-state pulse; default everything low/zero.
      resp_valid_o            <= 1'b0;
      resp_rdata_o            <= '0;
      resp_redirect_o         <= 1'b0;
      resp_target_o           <= '0;
      resp_illegal_o          <= 1'b0;
      csr_raddr_o             <= '0;
      csr_we_o                <= 1'b0;
      csr_waddr_o             <= '0;
      csr_wdata_o             <= '0;
      csr_we_mepc_o           <= 1'b0;
      csr_wdata_mepc_o        <= '0;
      csr_we_mcause_o         <= 1'b0;
      csr_wdata_mcause_o      <= '0;
      csr_exception_mie_req_o <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q        <= req_op_i;
            addr_q      <= req_addr_i;
            src_q       <= req_src_i;
            pc_q        <= req_pc_i;
            illegal_q   <= req_illegal(req_op_i, req_addr12, |req_src_i);
            req_ready_o <= 1'b0;
            state       <= ST_READ;
            if (req_op_i == OP_ECALL)     csr_raddr_o <= ADDR_W'(CSR_MTVEC);
            else if (req_op_i == OP_MRET) csr_raddr_o <= ADDR_W'(CSR_MSTATUS);
            else                          csr_raddr_o <= req_addr_i;
          end
        end

        ST_READ: begin
          old_q <= csr_rdata_i;
          if (op_q == OP_MRET) begin
            csr_raddr_o <= ADDR_W'(CSR_MEPC);
            state       <= ST_READ2;
          end else begin
            state <= ST_WRITE;
            if (!illegal_q && is_csr_op(op_q) && alu_wr) begin
              csr_we_o    <= 1'b1;
              csr_waddr_o <= addr_q;
              csr_wdata_o <= alu_new;
            end
            if (op_q == OP_ECALL) begin
              csr_we_mepc_o           <= 1'b1;
              csr_wdata_mepc_o        <= pc_q;
              csr_we_mcause_o         <= 1'b1;
              csr_wdata_mcause_o      <= XLEN'(CAUSE_ECALL_M);
              csr_exception_mie_req_o <= 1'b1;
            end
          end
        end

        ST_READ2: begin
          tgt_q       <= csr_rdata_i;
          state       <= ST_WRITE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= ADDR_W'(CSR_MSTATUS);
          csr_wdata_o <= mret_val;
        end

        ST_WRITE: begin
          state          <= ST_RESP;
          resp_valid_o   <= 1'b1;
          resp_illegal_o <= illegal_q;
          resp_rdata_o   <= (is_csr_op(op_q) && !illegal_q) ? old_q : '0;
          if (op_q == OP_ECALL) begin
            resp_redirect_o <= 1'b1;
            resp_target_o   <= old_q;
          end else if (op_q == OP_MRET) begin
            resp_redirect_o <= 1'b1;
            resp_target_o   <= tgt_q;
          end
        end

        ST_RESP: begin
          state       <= ST_IDLE;
          req_ready_o <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed table-driven bench for csr_ctrl with a small CSR-file read model.
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = '0;
  logic [11:0] req_addr_i = '0;
  logic [63:0] req_src_i = '0;
  logic [63:0] req_pc_i = '0;
  logic        resp_valid_o;
  logic [63:0] resp_rdata_o;
  logic        resp_redirect_o;
  logic [63:0] resp_target_o;
  logic        resp_illegal_o;
  logic [11:0] csr_raddr_o;
  logic [63:0] csr_rdata_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o;
  logic        csr_we_mepc_o;
  logic [63:0] csr_wdata_mepc_o;
  logic        csr_we_mcause_o;
  logic [63:0] csr_wdata_mcause_o;
  logic        csr_exception_mie_req_o;

  // CSR file contents seen by the DUT's combinational read port
  logic [63:0] cur_st = '0, cur_tv = '0, cur_ep = '0, cur_sc = '0;
  localparam logic [63:0] HARTID = 64'h3;

  always_comb begin
    case (csr_raddr_o)
      12'h300: csr_rdata_i = cur_st;
      12'h305: csr_rdata_i = cur_tv;
      12'h341: csr_rdata_i = cur_ep;
      12'h340: csr_rdata_i = cur_sc;
      12'hF14: csr_rdata_i = HARTID;
      default: csr_rdata_i = 64'h0;
    endcase
  end

  always #5 clk = ~clk;

  csr_ctrl #(.XLEN(64), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i),
    .req_src_i(req_src_i), .req_pc_i(req_pc_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_redirect_o(resp_redirect_o), .resp_target_o(resp_target_o),
    .resp_illegal_o(resp_illegal_o),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .csr_we_mepc_o(csr_we_mepc_o), .csr_wdata_mepc_o(csr_wdata_mepc_o),
    .csr_we_mcause_o(csr_we_mcause_o), .csr_wdata_mcause_o(csr_wdata_mcause_o),
    .csr_exception_mie_req_o(csr_exception_mie_req_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [63:0] src, pc, st, tv, ep, sc;
    logic        e_we;
    logic [11:0] e_waddr;
    logic [63:0] e_wdata;
    logic        e_exc;     // mepc/mcause/mie strobes expected
    logic [63:0] e_rdata;
    logic        e_redir;
    logic [63:0] e_tgt;
    logic        e_ill;
    int          e_lat;     // cycle of resp_valid_o after accept edge
  } vec_t;

  // Run one request; observe cycles T+1..T+7 and compare the recorded activity.
  task automatic run_vec(input vec_t v, input int idx);
    int we_n, we_c, ep_n, ep_c, mc_n, mie_n, rv_n, rv_c;
    logic [11:0] waddr;
    logic [63:0] wdata, epd, mcd, rd, tg;
    logic rdr, ill;
    string p;
    p = $sformatf("v%0d", idx);
    we_n = 0; we_c = 0; ep_n = 0; ep_c = 0; mc_n = 0; mie_n = 0; rv_n = 0; rv_c = 0;
    waddr = '0; wdata = '0; epd = '0; mcd = '0; rd = '0; tg = '0; rdr = 0; ill = 0;

    @(negedge clk);
    chk({p, " ready_before"}, 64'(req_ready_o), 64'd1);
    cur_st = v.st; cur_tv = v.tv; cur_ep = v.ep; cur_sc = v.sc;
    req_valid_i = 1'b1; req_op_i = v.op; req_addr_i = v.addr;
    req_src_i = v.src; req_pc_i = v.pc;
    @(posedge clk);  // accept edge T
    #1;
    req_valid_i = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (csr_we_o) begin we_n++; we_c = c; waddr = csr_waddr_o; wdata = csr_wdata_o; end
      if (csr_we_mepc_o) begin ep_n++; ep_c = c; epd = csr_wdata_mepc_o; end
      if (csr_we_mcause_o) begin mc_n++; mcd = csr_wdata_mcause_o; end
      if (csr_exception_mie_req_o) mie_n++;
      if (resp_valid_o) begin
        rv_n++; rv_c = c; rd = resp_rdata_o; rdr = resp_redirect_o;
        tg = resp_target_o; ill = resp_illegal_o;
      end
      @(posedge clk);
      #1;
    end

    chk({p, " we_count"},   64'(we_n), v.e_we ? 64'd1 : 64'd0);
    chk({p, " we_cycle"},   64'(we_c), v.e_we ? 64'(v.e_lat - 1) : 64'd0);
    chk({p, " waddr"},      64'(waddr), 64'(v.e_waddr));
    chk({p, " wdata"},      wdata, v.e_wdata);
    chk({p, " mepc_count"}, 64'(ep_n), v.e_exc ? 64'd1 : 64'd0);
    chk({p, " mepc_cycle"}, 64'(ep_c), v.e_exc ? 64'(v.e_lat - 1) : 64'd0);
    chk({p, " mepc_data"},  epd, v.e_exc ? v.pc : 64'd0);
    chk({p, " mcause_count"}, 64'(mc_n), v.e_exc ? 64'd1 : 64'd0);
    chk({p, " mcause_data"},  mcd, v.e_exc ? 64'd11 : 64'd0);
    chk({p, " mie_count"},  64'(mie_n), v.e_exc ? 64'd1 : 64'd0);
    chk({p, " resp_count"}, 64'(rv_n), 64'd1);
    chk({p, " resp_cycle"}, 64'(rv_c), 64'(v.e_lat));
    chk({p, " rdata"},      rd, v.e_rdata);
    chk({p, " redirect"},   64'(rdr), 64'(v.e_redir));
    chk({p, " target"},     tg, v.e_tgt);
    chk({p, " illegal"},    64'(ill), 64'(v.e_ill));
    chk({p, " ready_after"}, 64'(req_ready_o), 64'd1);
  endtask

  vec_t vecs[14];

  initial begin
    //          op      addr    src                 pc                  st                  tv                  ep                  sc      we waddr   wdata    exc rdata  redir tgt                ill lat
    vecs[0]  = '{3'b001, 12'h340, 64'hDEAD, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,                 1'b1, 12'h340, 64'hDEAD, 1'b0, 64'h0,  1'b0, 64'h0, 1'b0, 3};
    vecs[1]  = '{3'b010, 12'h300, 64'h8,    64'h0, 64'h80, 64'h0, 64'h0, 64'h0,                1'b1, 12'h300, 64'h88,   1'b0, 64'h80, 1'b0, 64'h0, 1'b0, 3};
    vecs[2]  = '{3'b011, 12'h300, 64'h0,    64'h0, 64'h80, 64'h0, 64'h0, 64'h0,                1'b0, 12'h000, 64'h0,    1'b0, 64'h80, 1'b0, 64'h0, 1'b0, 3};
    vecs[3]  = '{3'b011, 12'h340, 64'hF0,   64'h0, 64'h0, 64'h0, 64'h0, 64'hFF,                1'b1, 12'h340, 64'h0F,   1'b0, 64'hFF, 1'b0, 64'h0, 1'b0, 3};
    vecs[4]  = '{3'b100, 12'h000, 64'h0,    64'h8000_0010, 64'h0, 64'h8000_0100, 64'h0, 64'h0, 1'b0, 12'h000, 64'h0,    1'b1, 64'h0,  1'b1, 64'h8000_0100, 1'b0, 3};
    vecs[5]  = '{3'b101, 12'h000, 64'h0,    64'h0, 64'h80, 64'h0, 64'h8000_0014, 64'h0,        1'b1, 12'h300, 64'h88,   1'b0, 64'h0,  1'b1, 64'h8000_0014, 1'b0, 4};
    vecs[6]  = '{3'b101, 12'h000, 64'h0,    64'h0, 64'hFFFF_FFFF_FFFF_FF7F, 64'h0, 64'h1234, 64'h0, 1'b1, 12'h300, 64'h80, 1'b0, 64'h0, 1'b1, 64'h1234, 1'b0, 4};
    vecs[7]  = '{3'b001, 12'hF14, 64'h1,    64'h0, 64'h0, 64'h0, 64'h0, 64'h0,                 1'b0, 12'h000, 64'h0,    1'b0, 64'h0,  1'b0, 64'h0, 1'b1, 3};
    vecs[8]  = '{3'b001, 12'h7C0, 64'h5,    64'h0, 64'h0, 64'h0, 64'h0, 64'h0,                 1'b0, 12'h000, 64'h0,    1'b0, 64'h0,  1'b0, 64'h0, 1'b1, 3};
    vecs[9]  = '{3'b000, 12'h300, 64'h1,    64'h0, 64'h80, 64'h0, 64'h0, 64'h0,                1'b0, 12'h000, 64'h0,    1'b0, 64'h0,  1'b0, 64'h0, 1'b1, 3};
    vecs[10] = '{3'b111, 12'h340, 64'h1,    64'h0, 64'h0, 64'h0, 64'h0, 64'h77,                1'b0, 12'h000, 64'h0,    1'b0, 64'h0,  1'b0, 64'h0, 1'b1, 3};
    vecs[11] = '{3'b010, 12'hF14, 64'h0,    64'h0, 64'h0, 64'h0, 64'h0, 64'h0,                 1'b0, 12'h000, 64'h0,    1'b0, 64'h3,  1'b0, 64'h0, 1'b0, 3};
    vecs[12] = '{3'b001, 12'h340, 64'h0,    64'h0, 64'h0, 64'h0, 64'h0, 64'h55,                1'b1, 12'h340, 64'h0,    1'b0, 64'h55, 1'b0, 64'h0, 1'b0, 3};
    vecs[13] = '{3'b010, 12'h7C0, 64'h0,    64'h0, 64'h0, 64'h0, 64'h0, 64'h0,                 1'b0, 12'h000, 64'h0,    1'b0, 64'h0,  1'b0, 64'h0, 1'b1, 3};

    // Reset state
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset ready",      64'(req_ready_o), 64'd1);
    chk("reset resp_valid", 64'(resp_valid_o), 64'd0);
    chk("reset strobes",    64'({csr_we_o, csr_we_mepc_o, csr_we_mcause_o, csr_exception_mie_req_o}), 64'd0);
    chk("reset raddr",      64'(csr_raddr_o), 64'd0);
    chk("reset resp_data",  resp_rdata_o | resp_target_o | 64'({resp_redirect_o, resp_illegal_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reset during the WRITE cycle of an ECALL: the trap strobes must vanish
    // on that edge and the aborted request must never respond.
    begin
      int late_n;
      late_n = 0;
      @(negedge clk);
      cur_tv = 64'h8000_0100; cur_ep = 64'h0; cur_st = 64'h0;
      req_valid_i = 1'b1; req_op_i = 3'b100; req_addr_i = 12'h0;
      req_src_i = 64'h0; req_pc_i = 64'h8000_0010;
      @(posedge clk); #1;          // T+1: READ
      req_valid_i = 1'b0;
      @(posedge clk); #1;          // T+2: WRITE
      chk("rstw mepc_strobe_in_write", 64'(csr_we_mepc_o), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rstw strobes_after_edge", 64'({csr_we_o, csr_we_mepc_o, csr_we_mcause_o, csr_exception_mie_req_o}), 64'd0);
      chk("rstw ready",       64'(req_ready_o), 64'd1);
      chk("rstw resp_valid",  64'(resp_valid_o), 64'd0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        if (resp_valid_o || csr_we_o || csr_we_mepc_o || csr_we_mcause_o || csr_exception_mie_req_o)
          late_n++;
      end
      chk("rstw no_late_activity", 64'(late_n), 64'd0);
      chk("rstw idle_ready",       64'(req_ready_o), 64'd1);
    end

    // Operation resumes normally after the abort
    run_vec(vecs[1], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
